// File: rtl/descrambler_64bit.sv
// Self-synchronous x^58+x^39+1 descrambler for 64b/66b receive, with sync-header block lock and gearbox slip requests.
// Optional build macro DESCRAMBLER_ERR_CNT_EN adds a saturating invalid-header counter output (err_count).
module descrambler_64bit #(
    parameter int REVERSE    = 0,
    parameter int LOCK_COUNT = 64,
    parameter int WINDOW     = 64,
    parameter int BAD_LIMIT  = 16,
    parameter int SLIP_WAIT  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rx_valid,
    input  logic [1:0]  rx_header,
    input  logic [63:0] rx_data,
    output logic        out_valid,
    output logic [1:0]  out_header,
    output logic [63:0] out_data,
    output logic        block_lock,
    output logic        slip
`ifdef DESCRAMBLER_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int MAX_AB  = (LOCK_COUNT > WINDOW) ? LOCK_COUNT : WINDOW;
    localparam int MAX_CD  = (BAD_LIMIT > SLIP_WAIT) ? BAD_LIMIT : SLIP_WAIT;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [1:0] ST_HUNT      = 2'd0;
    localparam logic [1:0] ST_LOCKED    = 2'd1;
    localparam logic [1:0] ST_SLIP_HOLD = 2'd2;

    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] WIN_LIM  = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] BAD_LIM  = CNT_W'(BAD_LIMIT);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(SLIP_WAIT);

    logic [63:0] d_word;
    logic [63:0] descr;

    logic [57:0]      s_q, s_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_header_q, out_header_d;
    logic [63:0]      out_data_q, out_data_d;
    logic             lock_q, lock_d;
    logic             slip_q, slip_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] bad_q, bad_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic             hdr_ok;
    logic [CNT_W-1:0] good_inc, win_inc, bad_inc, wait_inc;

    // Taps reaching before bit 0 of this word come from the previous word (s_q).
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_bits
            logic tap39;
            logic tap58;
            if (REVERSE != 0) begin : g_rev
                assign d_word[gi] = rx_data[63-gi];
            end else begin : g_fwd
                assign d_word[gi] = rx_data[gi];
            end
            if (gi >= 39) begin : g_t39_cur
                assign tap39 = d_word[gi-39];
            end else begin : g_t39_prev
                assign tap39 = s_q[gi+19];
            end
            if (gi >= 58) begin : g_t58_cur
                assign tap58 = d_word[gi-58];
            end else begin : g_t58_prev
                assign tap58 = s_q[gi];
            end
            assign descr[gi] = d_word[gi] ^ tap39 ^ tap58;
        end
    endgenerate

    assign hdr_ok   = rx_header[1] ^ rx_header[0];
    assign good_inc = good_q + 1'b1;
    assign win_inc  = win_q + 1'b1;
    assign bad_inc  = bad_q + {{(CNT_W-1){1'b0}}, ~hdr_ok};
    assign wait_inc = wait_q + 1'b1;

    always_comb begin
        out_valid_d  = rx_valid;
        out_header_d = rx_valid ? rx_header : out_header_q;
        out_data_d   = rx_valid ? descr : out_data_q;
        s_d          = rx_valid ? d_word[63:6] : s_q;
        state_d      = state_q;
        good_d       = good_q;
        win_d        = win_q;
        bad_d        = bad_q;
        wait_d       = wait_q;
        lock_d       = lock_q;
        slip_d       = 1'b0;
        if (rx_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (!hdr_ok) begin
                        slip_d  = 1'b1;
                        state_d = ST_SLIP_HOLD;
                        good_d  = '0;
                    end else if (good_inc >= LOCK_LIM) begin
                        state_d = ST_LOCKED;
                        lock_d  = 1'b1;
                        good_d  = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end
                ST_LOCKED: begin
                    // Losing lock wins over a coincident window end.
                    if (bad_inc >= BAD_LIM) begin
                        lock_d  = 1'b0;
                        slip_d  = 1'b1;
                        state_d = ST_SLIP_HOLD;
                        win_d   = '0;
                        bad_d   = '0;
                    end else if (win_inc >= WIN_LIM) begin
                        win_d = '0;
                        bad_d = '0;
                    end else begin
                        win_d = win_inc;
                        bad_d = bad_inc;
                    end
                end
                ST_SLIP_HOLD: begin
                    if (wait_inc >= WAIT_LIM) begin
                        state_d = ST_HUNT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_inc;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    lock_d  = 1'b0;
                    good_d  = '0;
                    win_d   = '0;
                    bad_d   = '0;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_q          <= '1;
            out_valid_q  <= 1'b0;
            out_header_q <= 2'b00;
            out_data_q   <= '0;
            lock_q       <= 1'b0;
            slip_q       <= 1'b0;
            state_q      <= ST_HUNT;
            good_q       <= '0;
            win_q        <= '0;
            bad_q        <= '0;
            wait_q       <= '0;
        end else begin
            s_q          <= s_d;
            out_valid_q  <= out_valid_d;
            out_header_q <= out_header_d;
            out_data_q   <= out_data_d;
            lock_q       <= lock_d;
            slip_q       <= slip_d;
            state_q      <= state_d;
            good_q       <= good_d;
            win_q        <= win_d;
            bad_q        <= bad_d;
            wait_q       <= wait_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_header = out_header_q;
    assign out_data   = out_data_q;
    assign block_lock = lock_q;
    assign slip       = slip_q;

`ifdef DESCRAMBLER_ERR_CNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (rx_valid && !hdr_ok && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_descrambler_64bit.sv
// Directed bench for descrambler_64bit: seed, loopback through a scrambler model, hunt/slip, window limits, gaps, reset, REVERSE=1.
module tb_descrambler_64bit;

    localparam logic [63:0] SEED_OUT = 64'h03FF_FF80_0000_0000;

    logic        CLK;
    logic        RST;
    logic        rx_valid;
    logic [1:0]  rx_header;
    logic [63:0] rx_data;
    logic [63:0] rx_data_r;
    logic        out_valid, r_out_valid;
    logic [1:0]  out_header, r_out_header;
    logic [63:0] out_data, r_out_data;
    logic        block_lock, r_block_lock;
    logic        slip, r_slip;
`ifdef DESCRAMBLER_ERR_CNT_EN
    logic [15:0] err_count, r_err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [57:0] tx_state;

    descrambler_64bit #(.REVERSE(0)) dut (
        .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_header(rx_header), .rx_data(rx_data),
        .out_valid(out_valid), .out_header(out_header), .out_data(out_data),
        .block_lock(block_lock), .slip(slip)
`ifdef DESCRAMBLER_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    descrambler_64bit #(.REVERSE(1)) dut_r (
        .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_header(rx_header), .rx_data(rx_data_r),
        .out_valid(r_out_valid), .out_header(r_out_header), .out_data(r_out_data),
        .block_lock(r_block_lock), .slip(r_slip)
`ifdef DESCRAMBLER_ERR_CNT_EN
        , .err_count(r_err_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [63:0] bitrev(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    function automatic logic [63:0] pay(input int k);
        logic [31:0] kk;
        kk = k;
        return {32'hDEAD_0000 + kk, kk * 32'd3 + 32'h1357_0000};
    endfunction

    // Transmit-side scrambler: each scrambled bit feeds back into later taps.
    task automatic scramble(input logic [63:0] p, output logic [63:0] sc);
        logic [121:0] ext;
        ext = '0;
        ext[57:0] = tx_state;
        for (int i = 0; i < 64; i++) ext[58+i] = p[i] ^ ext[i+19] ^ ext[i];
        sc = ext[121:58];
        tx_state = ext[121:64];
    endtask

    task automatic send(input logic v, input logic [1:0] h, input logic [63:0] d);
        rx_valid  = v;
        rx_header = h;
        rx_data   = d;
        rx_data_r = bitrev(d);
        @(posedge CLK);
        #1;
    endtask

    task automatic send_block(input logic [1:0] h, input logic [63:0] p);
        logic [63:0] sc;
        scramble(p, sc);
        send(1'b1, h, sc);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        rx_valid = 1'b0; rx_header = 2'b00; rx_data = '0; rx_data_r = '0;
        @(posedge CLK); @(posedge CLK); #1;
        n_checks++;
        if ({out_valid, out_header, out_data, block_lock, slip} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b hdr=%b data=%h lock=%b slip=%b, want all 0",
                     out_valid, out_header, out_data, block_lock, slip);
        end
        RST = 1'b0;
        tx_state = '1;
    endtask

    task automatic test_seed;
        test_reset();
        send(1'b1, 2'b01, 64'd0);
        n_checks++;
        if (out_data !== SEED_OUT || out_valid !== 1'b1 || out_header !== 2'b01) begin
            n_fail++;
            $display("FAIL seed: got data=%h valid=%b hdr=%b, want data=%h valid=1 hdr=01",
                     out_data, out_valid, out_header, SEED_OUT);
        end
        send(1'b1, 2'b10, 64'd0);
        n_checks++;
        if (out_data !== 64'd0 || out_header !== 2'b10) begin
            n_fail++;
            $display("FAIL seed_state_zero: got data=%h hdr=%b, want data=0 hdr=10", out_data, out_header);
        end
    endtask

    task automatic test_loopback;
        logic [63:0] p;
        test_reset();
        for (int k = 1; k <= 200; k++) begin
            p = pay(k);
            send_block(2'b01, p);
            n_checks++;
            if (out_data !== p) begin
                n_fail++;
                $display("FAIL loopback_data k=%0d: got %h want %h", k, out_data, p);
            end
            n_checks++;
            if (r_out_data !== p) begin
                n_fail++;
                $display("FAIL reverse_data k=%0d: got %h want %h", k, r_out_data, p);
            end
            if (k == 63 || k == 64 || k == 200) begin
                n_checks++;
                if (block_lock !== (k >= 64) || r_block_lock !== (k >= 64)) begin
                    n_fail++;
                    $display("FAIL loopback_lock k=%0d: got %b/%b want %b", k, block_lock, r_block_lock, k >= 64);
                end
            end
        end
        n_checks++;
        if (slip !== 1'b0) begin
            n_fail++;
            $display("FAIL loopback_slip: got %b want 0", slip);
        end
        $display("loopback: 200 blocks, lock=%b", block_lock);
    endtask

    task automatic test_hunt_slip;
        test_reset();
        for (int k = 1; k <= 9; k++) send_block(2'b01, pay(k));
        send_block(2'b00, pay(10));
        n_checks++;
        if (slip !== 1'b1 || block_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL hunt_slip_pulse: got slip=%b lock=%b want slip=1 lock=0", slip, block_lock);
        end
        for (int k = 1; k <= 8; k++) begin
            send_block(2'b11, pay(10 + k));
            n_checks++;
            if (slip !== 1'b0) begin
                n_fail++;
                $display("FAIL hunt_slip_hold k=%0d: got slip=%b want 0", k, slip);
            end
        end
        for (int k = 1; k <= 64; k++) begin
            send_block(2'b01, pay(100 + k));
            if (k >= 63) begin
                n_checks++;
                if (block_lock !== (k == 64) || slip !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hunt_relock k=%0d: got lock=%b slip=%b want lock=%b slip=0",
                             k, block_lock, slip, k == 64);
                end
            end
        end
        $display("hunt_slip: relock=%b", block_lock);
    endtask

    // Enters locked; runs windows of 15 bad, 15 bad, 16 bad, then 16 bad at window end.
    task automatic test_window;
        for (int w = 0; w < 2; w++) begin
            for (int k = 1; k <= 64; k++) send_block((k <= 15) ? 2'b11 : 2'b10, pay(k));
            n_checks++;
            if (block_lock !== 1'b1 || slip !== 1'b0) begin
                n_fail++;
                $display("FAIL window_15bad w=%0d: got lock=%b slip=%b want lock=1 slip=0", w, block_lock, slip);
            end
        end
        for (int k = 1; k <= 15; k++) send_block(2'b00, pay(k));
        n_checks++;
        if (block_lock !== 1'b1 || slip !== 1'b0) begin
            n_fail++;
            $display("FAIL window_15th: got lock=%b slip=%b want lock=1 slip=0", block_lock, slip);
        end
        send_block(2'b00, pay(16));
        n_checks++;
        if (block_lock !== 1'b0 || slip !== 1'b1) begin
            n_fail++;
            $display("FAIL window_16th: got lock=%b slip=%b want lock=0 slip=1", block_lock, slip);
        end
        for (int k = 1; k <= 72; k++) send_block(2'b01, pay(k));
        n_checks++;
        if (block_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL window_relock: got lock=%b want 1", block_lock);
        end
        for (int k = 1; k <= 63; k++) send_block((k <= 48) ? 2'b01 : 2'b11, pay(k));
        n_checks++;
        if (block_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL window_end_15bad: got lock=%b want 1", block_lock);
        end
        send_block(2'b11, pay(64));
        n_checks++;
        if (block_lock !== 1'b0 || slip !== 1'b1) begin
            n_fail++;
            $display("FAIL window_end_precedence: got lock=%b slip=%b want lock=0 slip=1", block_lock, slip);
        end
        $display("window: lock=%b slip=%b after end-coincident 16th bad", block_lock, slip);
    endtask

    task automatic test_gaps;
        logic [63:0] p;
        test_reset();
        for (int k = 1; k <= 64; k++) begin
            p = pay(k);
            send_block(2'b01, p);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== p) begin
                n_fail++;
                $display("FAIL gaps_valid k=%0d: got valid=%b data=%h want valid=1 data=%h", k, out_valid, out_data, p);
            end
            send(1'b0, 2'b00, 64'hFFFF_0000_FFFF_0000);
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== p || out_header !== 2'b01) begin
                n_fail++;
                $display("FAIL gaps_idle k=%0d: got valid=%b data=%h hdr=%b want valid=0 data=%h hdr=01",
                         k, out_valid, out_data, out_header, p);
            end
            if (k >= 63) begin
                n_checks++;
                if (block_lock !== (k == 64)) begin
                    n_fail++;
                    $display("FAIL gaps_lock k=%0d: got %b want %b", k, block_lock, k == 64);
                end
            end
        end
        $display("gaps: lock=%b", block_lock);
    endtask

    task automatic test_reset_mid;
        send_block(2'b01, pay(65));
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_header, out_data, block_lock, slip} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got valid=%b hdr=%b data=%h lock=%b slip=%b want all 0",
                     out_valid, out_header, out_data, block_lock, slip);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        send(1'b1, 2'b01, 64'd0);
        tx_state = '0;
        n_checks++;
        if (out_data !== SEED_OUT || block_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_seed: got data=%h lock=%b want data=%h lock=0", out_data, block_lock, SEED_OUT);
        end
        for (int k = 2; k <= 64; k++) begin
            send_block(2'b01, pay(k));
            if (k >= 63) begin
                n_checks++;
                if (block_lock !== (k == 64)) begin
                    n_fail++;
                    $display("FAIL reset_mid_relock k=%0d: got %b want %b", k, block_lock, k == 64);
                end
            end
        end
        $display("reset_mid: relock=%b", block_lock);
    endtask

    initial begin
        RST = 1'b1;
        rx_valid = 1'b0; rx_header = 2'b00; rx_data = '0; rx_data_r = '0;
        tx_state = '1;
        test_reset();
        test_seed();
        test_loopback();
        test_hunt_slip();
        test_window();
        test_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/descrambler_64bit.md
Name: descrambler_64bit

Overview:
- Receive-side inverse of the 64-bit parallel x^58+x^39+1 scrambler, for a 10GBASE-R style 64b/66b path.
- Sits between the RX gearbox and the block decoder.
- Self-synchronously descrambles 64-bit payloads and runs a sync-header block-lock state machine.
- Requests bit-slips from the gearbox until lock is found.

Parameters:
- REVERSE, 0: 0 = rx_data[0] is the first bit on the wire. 1 = rx_data is bit-reversed (rx_data[63] first) and is un-reversed before descrambling. Output is always LSB-first.
- LOCK_COUNT, 64: consecutive valid sync headers required to acquire lock.
- WINDOW, 64: headers per bad-header test window while locked.
- BAD_LIMIT, 16: invalid headers within one window that drop lock.
- SLIP_WAIT, 8: valid blocks ignored after a slip request.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- rx_valid  in  1  rx_header/rx_data are valid this cycle
- rx_header  in  2  sync header
- rx_data  in  64  scrambled payload
- out_valid  out  1  registered rx_valid
- out_header  out  2  registered rx_header
- out_data  out  64  descrambled payload
- block_lock  out  1  lock status
- slip  out  1  one-cycle bit-slip request to gearbox

Behaviour:
- Reset (async, RST=1):
  - out_valid, out_header, out_data, block_lock, slip are all 0.
  - Descrambler state s[57:0] is all ones, matching the scrambler seed.
  - FSM enters HUNT; all counters are 0.
- Descrambling, per bit i of the 64-bit word (d = un-reversed rx_data):
  - out[i] = d[i] ^ x[i-39] ^ x[i-58].
  - x[k] = d[k] for k>=0; x[k] = s[58+k] for k<0. s[0] is the oldest stored bit.
- State update: on rx_valid, s <= d[63:6].
- Data path latency: 1 cycle.
  - On rx_valid: out_valid=1, out_header, out_data registered.
  - Otherwise out_valid=0; out_data and out_header hold.
- Data is descrambled in every FSM state; block_lock qualifies it downstream.
- Header classification: valid = 2'b01 or 2'b10; invalid = 2'b00 or 2'b11.
- Header counting: only cycles with rx_valid=1 count; with rx_valid=0, counters and FSM hold.
- FSM states:
  - HUNT:
    - Valid header: good_cnt++.
    - good_cnt reaches LOCK_COUNT: go to LOCKED, block_lock=1 the next cycle, clear counters.
    - Invalid header: slip=1 for one cycle, go to SLIP_HOLD, clear counters.
  - LOCKED:
    - Each header: win_cnt++; invalid header: bad_cnt++.
    - bad_cnt reaches BAD_LIMIT: block_lock=0, slip=1, go to SLIP_HOLD, clear counters. This takes precedence if it coincides with the window end.
    - win_cnt reaches WINDOW with bad_cnt < BAD_LIMIT: clear both counters, stay LOCKED.
  - SLIP_HOLD:
    - Count SLIP_WAIT valid blocks, ignoring headers.
    - Then go to HUNT with counters cleared.
- slip is never asserted on two consecutive cycles.
- Counter widths: $clog2(max parameter)+1; counters never wrap.
- Reset mid-lock: immediate return to the reset values above.

Optional Feature:
- Macro: DESCRAMBLER_ERR_CNT_EN.
- Defined:
  - Adds output port err_count [15:0]: saturating count of invalid headers seen with rx_valid=1, in any state.
  - Saturates at 16'hFFFF; cleared only by RST.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Seed check: after reset, rx_valid=1, rx_header=01, rx_data=0 -> next cycle out_data=64'h03FF_FF80_0000_0000, out_valid=1, s=0.
- Loopback: scrambler_64bit feeds this block, 200 blocks of incrementing payload with header 01 -> out_data equals payload from the first block; block_lock rises after block 64 with 1-cycle latency.
- Hunt slip: invalid header 00 on block 10 in HUNT -> slip=1 for exactly one cycle, no lock; 8 ignored blocks, then 64 good headers -> lock.
- Window limits: in LOCKED, 15 headers of 11 within a 64-block window -> lock held, counters cleared at window end. 16 in one window -> block_lock=0 and slip=1 on the cycle after the 16th.
- Gaps: rx_valid toggling 1/0 every cycle during the loopback test -> same out_data sequence, lock after 64 valid blocks, out_valid mirrors rx_valid delayed by 1.
- Reset mid-operation: RST pulsed while locked -> all outputs 0 asynchronously; state all ones; relock needs 64 fresh valid headers.
- REVERSE=1: bit-reversed scrambler output -> identical out_data to the REVERSE=0 loopback test.
